// File: rtl/hilo_seq_unit.sv
// hilo_seq_unit: HI/LO register unit with a one-cycle multiplier and a
// 32-cycle unsigned restoring divider.
// Optional feature macro: DIVZERO_TRAP_EN. When it is defined, an IDLE
// divide by zero does not start and instead pulses divzero_trap_md for
// one cycle. When it is undefined, the port is absent and a divide by zero
// runs the full 32 cycles, giving HI = A and LO = 32'hFFFFFFFF.
//
// Request handshake: a request is taken only in IDLE. While busy_md is
// high every request is ignored, and stall_md tells upstream to hold it.
module hilo_seq_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] sourceA_ex,
  input  logic [31:0] sourceB_ex,
  input  logic        mult_ex,
  input  logic        div_ex,
  input  logic        mthi_ex,
  input  logic        mtlo_ex,
  input  logic        mfhi_ex,
  input  logic        mflo_ex,
  output logic [31:0] rd_data_md,
  output logic [31:0] hi_md,
  output logic [31:0] lo_md,
  output logic        busy_md,
  output logic        stall_md
`ifdef DIVZERO_TRAP_EN
  ,
  output logic        divzero_trap_md
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // a_q holds the dividend and is shifted into the quotient during DIV.
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
`ifdef DIVZERO_TRAP_EN
  logic        trap_q, trap_d;
`endif

  logic        start;
  logic [63:0] prod;
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // One restoring-division step and the full product, both from latched operands.
  always_comb begin
    prod     = {32'd0, a_q} * {32'd0, b_q};
    shifted  = {rem_q, a_q[31]};
    ge       = (shifted >= {1'b0, b_q});
    trial    = shifted[31:0] - b_q;
    rem_next = ge ? trial : shifted[31:0];
    quo_next = {a_q[30:0], ge};
  end

  // Next-state logic: request acceptance, moves, and per-state datapath updates.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    start   = mult_ex ^ div_ex;
`ifdef DIVZERO_TRAP_EN
    trap_d  = 1'b0;
    if (div_ex && !mult_ex && (sourceB_ex == 32'd0)) begin
      start  = 1'b0;
      trap_d = (state_q == ST_IDLE);
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = sourceA_ex;
          b_d     = sourceB_ex;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = mult_ex ? ST_MUL : ST_DIV;
        end else if (!mult_ex && !div_ex) begin
          if (mthi_ex) hi_d = sourceA_ex;
          if (mtlo_ex) lo_d = sourceA_ex;
        end
      end
      ST_MUL: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        state_d = ST_IDLE;
      end
      ST_DIV: begin
        rem_d = rem_next;
        a_d   = quo_next;
        if (cnt_q == 5'd31) begin
          hi_d    = rem_next;
          lo_d    = quo_next;
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      cnt_q   <= 5'd0;
`ifdef DIVZERO_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
`ifdef DIVZERO_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  // Outputs: register views, read mux (HI has priority) and stall.
  always_comb begin
    hi_md    = hi_q;
    lo_md    = lo_q;
    busy_md  = (state_q != ST_IDLE);
    stall_md = busy_md & (mult_ex | div_ex | mthi_ex | mtlo_ex | mfhi_ex | mflo_ex);
    if (mfhi_ex)      rd_data_md = hi_q;
    else if (mflo_ex) rd_data_md = lo_q;
    else              rd_data_md = 32'd0;
  end

`ifdef DIVZERO_TRAP_EN
  assign divzero_trap_md = trap_q;
`endif

endmodule

// File: tb/tb_hilo_seq_unit.sv
// Testbench for hilo_seq_unit: a behavioural HI/LO model checked against the
// DUT on every negative edge, plus directed scenarios with literal values.
module tb_hilo_seq_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] sourceA_ex, sourceB_ex;
  logic        mult_ex, div_ex, mthi_ex, mtlo_ex, mfhi_ex, mflo_ex;
  logic [31:0] rd_data_md, hi_md, lo_md;
  logic        busy_md, stall_md;
`ifdef DIVZERO_TRAP_EN
  logic        divzero_trap_md;
`endif

  hilo_seq_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sourceA_ex (sourceA_ex),
    .sourceB_ex (sourceB_ex),
    .mult_ex    (mult_ex),
    .div_ex     (div_ex),
    .mthi_ex    (mthi_ex),
    .mtlo_ex    (mtlo_ex),
    .mfhi_ex    (mfhi_ex),
    .mflo_ex    (mflo_ex),
    .rd_data_md (rd_data_md),
    .hi_md      (hi_md),
    .lo_md      (lo_md),
    .busy_md    (busy_md),
    .stall_md   (stall_md)
`ifdef DIVZERO_TRAP_EN
    ,
    .divzero_trap_md (divzero_trap_md)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left counts the busy cycles still to go; results land when it hits 0.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  logic        m_trap;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_trap = 0;
    end else begin
      m_trap = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (mult_ex && !div_ex) begin
        {p_hi, p_lo} = {32'd0, sourceA_ex} * {32'd0, sourceB_ex};
        m_left = 1;
      end else if (div_ex && !mult_ex) begin
        if (sourceB_ex == 0) begin
`ifdef DIVZERO_TRAP_EN
          m_trap = 1;
`else
          p_hi = sourceA_ex;
          p_lo = 32'hFFFFFFFF;
          m_left = 32;
`endif
        end else begin
          p_hi = sourceA_ex % sourceB_ex;
          p_lo = sourceA_ex / sourceB_ex;
          m_left = 32;
        end
      end else if (!mult_ex && !div_ex) begin
        if (mthi_ex) m_hi = sourceA_ex;
        if (mtlo_ex) m_lo = sourceA_ex;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic        any_req;
      logic [31:0] exp_rd;
      any_req = mult_ex | div_ex | mthi_ex | mtlo_ex | mfhi_ex | mflo_ex;
      exp_rd  = mfhi_ex ? m_hi : (mflo_ex ? m_lo : 32'd0);
      chk("model_hi", hi_md, m_hi);
      chk("model_lo", lo_md, m_lo);
      chk("model_busy", {31'd0, busy_md}, {31'd0, m_left != 0});
      chk("model_stall", {31'd0, stall_md}, {31'd0, (m_left != 0) && any_req});
      chk("model_rd", rd_data_md, exp_rd);
`ifdef DIVZERO_TRAP_EN
      chk("model_trap", {31'd0, divzero_trap_md}, {31'd0, m_trap});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mult_ex = 0; div_ex = 0; mthi_ex = 0; mtlo_ex = 0; mfhi_ex = 0; mflo_ex = 0;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy_md && cycles < 40) begin
      tick();
      cycles++;
    end
    chk(name, {31'd0, busy_md}, 32'd0);
  endtask

  // Directed operation table run through the model.
  logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_b  [6] = '{32'd1, 32'd100, 32'd3, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic        t_div[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cyc;
    int stall_cnt;
    reset_n = 0;
    sourceA_ex = 0; sourceB_ex = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_hi", hi_md, 32'd0);
    chk("reset_lo", lo_md, 32'd0);
    chk("reset_busy", {31'd0, busy_md}, 32'd0);
    reset_n = 1;

    // Moves, read-before-write in the same cycle.
    sourceA_ex = 32'h1234; mthi_ex = 1; mfhi_ex = 1;
    #1 chk("rd_pre_write", rd_data_md, 32'd0);
    tick();
    mthi_ex = 0; mtlo_ex = 1; sourceA_ex = 32'h5678;
    #1 chk("rd_hi_after_mthi", rd_data_md, 32'h1234);
    tick();
    clr();
    chk("mthi_hi", hi_md, 32'h1234);
    chk("mtlo_lo", lo_md, 32'h5678);

    // Multiply FFFFFFFF * 2.
    sourceA_ex = 32'hFFFFFFFF; sourceB_ex = 32'd2; mult_ex = 1;
    tick();
    clr();
    chk("mul_busy_n1", {31'd0, busy_md}, 32'd1);
    chk("mul_hi_unchanged", hi_md, 32'h1234);
    tick();
    chk("mul_busy_n2", {31'd0, busy_md}, 32'd0);
    chk("mul_hi", hi_md, 32'd1);
    chk("mul_lo", lo_md, 32'hFFFFFFFE);
    mflo_ex = 1;
    #1 chk("mul_rd_lo", rd_data_md, 32'hFFFFFFFE);
    clr();

    // Divide 100 / 7 with mflo held from the first busy cycle.
    sourceA_ex = 32'd100; sourceB_ex = 32'd7; div_ex = 1;
    tick();
    clr();
    mflo_ex = 1;
    stall_cnt = 0;
    while (stall_md && stall_cnt < 40) begin
      stall_cnt++;
      tick();
    end
    chk("div_stall_cycles", stall_cnt, 32'd32);
    chk("div_rd_lo", rd_data_md, 32'd14);
    chk("div_hi", hi_md, 32'd2);
    clr();

    // Reset in DIV cycle 10.
    sourceA_ex = 32'd100; sourceB_ex = 32'd7; div_ex = 1;
    tick();
    clr();
    repeat (9) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    mflo_ex = 1;
    #1;
    chk("rst_busy", {31'd0, busy_md}, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    chk("rst_hi", hi_md, 32'd0);
    chk("rst_lo", lo_md, 32'd0);
    chk("rst_rd", rd_data_md, 32'd0);
    tick();
    clr();

    // Collisions: mthi plus mult, then mult plus div.
    sourceA_ex = 32'd5; sourceB_ex = 32'd3; mthi_ex = 1; mult_ex = 1;
    tick();
    clr();
    tick();
    chk("coll_hi", hi_md, 32'd0);
    chk("coll_lo", lo_md, 32'd15);
    sourceA_ex = 32'd77; sourceB_ex = 32'd2; mult_ex = 1; div_ex = 1;
    tick();
    chk("both_busy", {31'd0, busy_md}, 32'd0);
    clr();
    tick();
    chk("both_hi", hi_md, 32'd0);
    chk("both_lo", lo_md, 32'd15);

    // Requests during a divide are ignored.
    sourceA_ex = 32'd1000; sourceB_ex = 32'd10; div_ex = 1;
    tick();
    clr();
    sourceA_ex = 32'hAAAA; mthi_ex = 1; mult_ex = 1;
    repeat (5) tick();
    clr();
    wait_idle("busy_ign_timeout", cyc);
    chk("busy_ign_hi", hi_md, 32'd0);
    chk("busy_ign_lo", lo_md, 32'd100);

    // Divide by zero, A = 9.
    sourceA_ex = 32'd9; sourceB_ex = 32'd0; div_ex = 1;
    tick();
    clr();
`ifdef DIVZERO_TRAP_EN
    chk("dz_trap_on", {31'd0, divzero_trap_md}, 32'd1);
    chk("dz_busy", {31'd0, busy_md}, 32'd0);
    tick();
    chk("dz_trap_off", {31'd0, divzero_trap_md}, 32'd0);
    chk("dz_hi", hi_md, 32'd0);
    chk("dz_lo", lo_md, 32'd100);
`else
    wait_idle("dz_timeout", cyc);
    chk("dz_cycles", cyc, 32'd32);
    chk("dz_hi", hi_md, 32'd9);
    chk("dz_lo", lo_md, 32'hFFFFFFFF);
`endif

    // Table of further operations, checked by the model each cycle.
    for (int i = 0; i < 6; i++) begin
      sourceA_ex = t_a[i]; sourceB_ex = t_b[i];
      div_ex = t_div[i]; mult_ex = !t_div[i];
      tick();
      clr();
      mfhi_ex = 1;
      wait_idle("table_timeout", cyc);
      tick();
      clr();
    end
    chk("tbl_div_hi", hi_md, 32'd0);
    chk("tbl_div_lo", lo_md, 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
